// File: rtl/mem_access_stage_if.sv
// Data-memory port between the MEM pipeline stage and the data memory.
// Latency: none (wires only); the master holds req until ack.
// Backpressure: the memory stretches an access by withholding dmem_ack.
interface mem_access_stage_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;

    // Pipeline stage side: issues requests, receives completion
    modport master (
        output dmem_req,
        output dmem_we,
        output dmem_addr,
        output dmem_wdata,
        input  dmem_rdata,
        input  dmem_ack
    );

    // Memory side: accepts requests, returns data and ack
    modport slave (
        input  dmem_req,
        input  dmem_we,
        input  dmem_addr,
        input  dmem_wdata,
        output dmem_rdata,
        output dmem_ack
    );
endinterface

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: passes ALU results to MEM/WB, runs load/store accesses on the data-memory port.
// Latency: 1 cycle for non-memory instructions; memory ops take accept + wait + 1 DONE cycle.
// Backpressure: stall_out holds EX/MEM while an access is pending; optional MEM_TIMEOUT_EN aborts stuck accesses.
module mem_access_stage #(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [31:0]         result_in,
    input  logic [31:0]         registro_2_in,
    input  logic [10:0]         jump_dest_addr_in,
    input  logic                zero_signal_in,
    input  logic [4:0]          reg_dest_in,
    input  logic                MemToReg_in,
    input  logic                RegWrite_in,
    input  logic                MemRead_in,
    input  logic                MemWrite_in,
    input  logic                Branch_in,
    mem_access_stage_if.master  dmem,
    output logic                stall_out,
    output logic                pc_src_out,
    output logic [10:0]         branch_addr_out,
    output logic [31:0]         read_data_out,
    output logic [31:0]         result_out,
    output logic [4:0]          reg_dest_out,
    output logic                MemToReg_out,
    output logic                RegWrite_out,
    output logic                mem_error
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]  r_state;
    logic        r_req;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_is_load;
    logic [4:0]  r_reg_dest_l;
    logic        r_mem_to_reg_l;
    logic        r_reg_write_l;

    logic [31:0] r_read_data;
    logic [31:0] r_result;
    logic [4:0]  r_reg_dest;
    logic        r_mem_to_reg;
    logic        r_reg_write;

    logic        w_mem_instr;
    logic        w_timeout;

    assign w_mem_instr = MemRead_in | MemWrite_in;

    `ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] r_busy_cnt;
    logic             r_mem_error;

    // Last BUSY cycle of the allowed window with still no ack
    assign w_timeout = (r_state == S_BUSY) && !dmem.dmem_ack &&
                       (r_busy_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Count BUSY cycles without ack; cleared whenever the FSM leaves BUSY
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            r_busy_cnt <= '0;
        else if (r_state != S_BUSY)
            r_busy_cnt <= '0;
        else if (!dmem.dmem_ack)
            r_busy_cnt <= r_busy_cnt + 1'b1;
    end

    // Sticky error flag, cleared only by reset
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            r_mem_error <= 1'b0;
        else if (w_timeout)
            r_mem_error <= 1'b1;
    end

    assign mem_error = r_mem_error;
    `else
    assign w_timeout = 1'b0;
    assign mem_error = 1'b0;
    `endif

    // FSM, access latches and MEM/WB register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_req          <= 1'b0;
            r_we           <= 1'b0;
            r_addr         <= '0;
            r_wdata        <= '0;
            r_is_load      <= 1'b0;
            r_reg_dest_l   <= '0;
            r_mem_to_reg_l <= 1'b0;
            r_reg_write_l  <= 1'b0;
            r_read_data    <= '0;
            r_result       <= '0;
            r_reg_dest     <= '0;
            r_mem_to_reg   <= 1'b0;
            r_reg_write    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_mem_instr) begin
                        // Read+write together is a store; the read is dropped
                        r_addr         <= result_in;
                        r_wdata        <= registro_2_in;
                        r_we           <= MemWrite_in;
                        r_is_load      <= MemRead_in & ~MemWrite_in;
                        r_reg_dest_l   <= reg_dest_in;
                        r_mem_to_reg_l <= MemToReg_in;
                        r_reg_write_l  <= RegWrite_in;
                        r_req          <= 1'b1;
                        r_reg_write    <= 1'b0;
                        r_state        <= S_BUSY;
                    end else begin
                        r_result     <= result_in;
                        r_reg_dest   <= reg_dest_in;
                        r_mem_to_reg <= MemToReg_in;
                        r_reg_write  <= RegWrite_in;
                    end
                end
                S_BUSY: begin
                    if (dmem.dmem_ack) begin
                        r_req        <= 1'b0;
                        r_result     <= r_addr;
                        r_reg_dest   <= r_reg_dest_l;
                        r_mem_to_reg <= r_mem_to_reg_l;
                        r_reg_write  <= r_reg_write_l;
                        if (r_is_load)
                            r_read_data <= dmem.dmem_rdata;
                        r_state      <= S_DONE;
                    end else if (w_timeout) begin
                        r_req       <= 1'b0;
                        r_reg_write <= 1'b0;
                        r_state     <= S_DONE;
                    end else begin
                        r_reg_write <= 1'b0;
                    end
                end
                S_DONE: begin
                    // Inputs are still the completed instruction; do not re-issue it
                    r_reg_write <= 1'b0;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Upstream hold: accepting a memory op, or waiting for ack
    always_comb begin
        stall_out = 1'b0;
        if (!reset) begin
            if (r_state == S_IDLE)
                stall_out = w_mem_instr;
            else if (r_state == S_BUSY)
                stall_out = ~dmem.dmem_ack;
        end
    end

    assign pc_src_out      = Branch_in & zero_signal_in & (r_state != S_DONE);
    assign branch_addr_out = jump_dest_addr_in;

    assign dmem.dmem_req   = r_req;
    assign dmem.dmem_we    = r_we;
    assign dmem.dmem_addr  = r_addr;
    assign dmem.dmem_wdata = r_wdata;

    assign read_data_out = r_read_data;
    assign result_out    = r_result;
    assign reg_dest_out  = r_reg_dest;
    assign MemToReg_out  = r_mem_to_reg;
    assign RegWrite_out  = r_reg_write;

endmodule

// File: doc/mem_access_stage.md
MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 15, number of BUSY cycles without dmem_ack before the access is aborted (used only with MEM_TIMEOUT_EN).
REQ-002 clock  input  1  single clock; all state changes on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 result_in  input  32  ALU result from EX/MEM; memory address for loads and stores.
REQ-005 registro_2_in  input  32  store data from EX/MEM.
REQ-006 jump_dest_addr_in  input  11  branch target from EX/MEM.
REQ-007 zero_signal_in  input  1  ALU zero flag from EX/MEM.
REQ-008 reg_dest_in  input  5  destination register from EX/MEM.
REQ-009 MemToReg_in, RegWrite_in, MemRead_in, MemWrite_in, Branch_in  input  1 each  EX/MEM control signals.
REQ-010 dmem_req / dmem_we  output  1 / 1  data memory request; write enable (1 = store).
REQ-011 dmem_addr / dmem_wdata  output  32 / 32  latched address; latched store data.
REQ-012 dmem_rdata / dmem_ack  input  32 / 1  load data; single-cycle completion strobe.
REQ-013 stall_out  output  1  upstream hold; EX/MEM inputs stay unchanged while high.
REQ-014 pc_src_out / branch_addr_out  output  1 / 11  branch taken; branch target.
REQ-015 read_data_out, result_out  output  32 each  registered MEM/WB load data; registered ALU result.
REQ-016 reg_dest_out  output  5; MemToReg_out, RegWrite_out  output  1 each  registered MEM/WB fields.
REQ-017 mem_error  output  1  sticky memory timeout flag.

Function
REQ-018 FSM states are IDLE, BUSY, and DONE; a memory instruction is MemRead_in or MemWrite_in high.
REQ-019 IDLE, no memory instruction: at each edge, result_out, reg_dest_out, MemToReg_out, and RegWrite_out load from their inputs (1-cycle latency); read_data_out holds; stall_out = 0.
REQ-020 IDLE, memory instruction: stall_out = 1 combinationally; at the edge, latch address, data, write flag, and control fields; set dmem_req = 1; go to BUSY; RegWrite_out loads 0.
REQ-021 BUSY: dmem_req stays 1; stall_out = 1 while dmem_ack = 0; RegWrite_out = 0 (bubble) on every edge without ack.
REQ-022 BUSY with dmem_ack = 1: stall_out = 0 in that cycle; at the edge, dmem_req drops; MEM/WB outputs load the latched fields; read_data_out loads dmem_rdata for a load; go to DONE.
REQ-023 DONE: lasts one cycle; stall_out = 0; the held EX/MEM inputs do not retrigger an access; RegWrite_out loads 0; go to IDLE.
REQ-024 Stores: read_data_out holds; RegWrite_out = latched RegWrite_in.
REQ-025 MemRead_in and MemWrite_in both high: treated as a store; the read is discarded.
REQ-026 dmem_ack is ignored outside BUSY; the earliest ack is one cycle after dmem_req rises.
REQ-027 pc_src_out = Branch_in AND zero_signal_in, forced to 0 in DONE; branch_addr_out = jump_dest_addr_in; both are combinational.
REQ-028 dmem_addr, dmem_wdata, and dmem_we are stable for the whole time dmem_req is high.

Reset
REQ-029 reset high forces the FSM to IDLE immediately, without waiting for a clock edge.
REQ-030 reset high forces dmem_req, dmem_we, stall_out, mem_error, all MEM/WB outputs, and all latches to 0; this applies mid-access too, and the access is abandoned.
REQ-031 After reset deasserts, the first edge is processed as IDLE.

Configuration
REQ-032 Macro MEM_TIMEOUT_EN defined: a BUSY-cycle counter runs.
REQ-033 With MEM_TIMEOUT_EN, after TIMEOUT_CYCLES BUSY cycles without ack: dmem_req drops, mem_error sets (sticky until reset), the FSM goes to DONE, and RegWrite_out = 0 (the load is discarded).
REQ-034 Macro MEM_TIMEOUT_EN undefined: no counter; BUSY waits indefinitely; mem_error is tied to 0.

Verification
REQ-035 ALU instruction, result_in=0x0000_00A5, reg_dest_in=7, RegWrite_in=1 -> next edge: result_out=0xA5, reg_dest_out=7, RegWrite_out=1, stall_out=0 throughout.
REQ-036 Load from 0x40, ack 3 cycles after req with rdata 0xDEAD_BEEF -> stall_out high from accept to the ack cycle; read_data_out=0xDEADBEEF and RegWrite_out=1 for one cycle; DONE then gives RegWrite_out=0 with no second request.
REQ-037 Store 0x1234_5678 to 0x80 with MemRead_in also high -> dmem_we=1, dmem_wdata=0x12345678, dmem_addr=0x80; read_data_out unchanged.
REQ-038 Branch_in=1, zero_signal_in=1, jump_dest_addr_in=0x155 -> pc_src_out=1, branch_addr_out=0x155 in the same cycle; with zero_signal_in=0 -> pc_src_out=0.
REQ-039 reset pulsed two cycles into a pending load -> dmem_req=0 and stall_out=0 immediately; a late ack after reset causes no output change.
REQ-040 With MEM_TIMEOUT_EN and no ack -> after 15 BUSY cycles: mem_error=1, dmem_req=0, RegWrite_out=0; mem_error stays 1 until reset.
